// File: rtl/rf_alu_sequencer.sv
// Command-driven ALU sequencer that masters a 16x32 register file:
// reads two sources, computes one ALU operation, writes the result back.
module rf_alu_sequencer #(
   parameter int DW = 32,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [AW-1:0] cmd_rs1,
   input  logic [AW-1:0] cmd_rs2,
   input  logic [AW-1:0] cmd_rd,
   output logic          rf_en,
   output logic          rf_rd,
   output logic          rf_wr,
   output logic [AW-1:0] rf_sel_o1,
   output logic [AW-1:0] rf_sel_o2,
   output logic [AW-1:0] rf_sel_i1,
   output logic [DW-1:0] rf_wdata,
   input  logic [DW-1:0] rf_op_1,
   input  logic [DW-1:0] rf_op_2,
   output logic          res_valid,
   output logic [DW-1:0] res_data,
   output logic          res_zero,
   output logic          res_carry
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_EX, S_WB} state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_CMP = 3'b111;

   state_t          state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [AW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [DW-1:0]   res_q, res_d;
   logic            zero_q, zero_d, carry_q, carry_d;

   logic [DW:0]     sum_ext;
   logic [DW-1:0]   alu_res;
   logic            alu_carry;

   assign sum_ext = {1'b0, rf_op_1} + {1'b0, rf_op_2};

   // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned (no latch).
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      case (op_q)
         OP_ADD: begin
            alu_res   = sum_ext[DW-1:0];
            alu_carry = sum_ext[DW];
         end
         OP_SUB, OP_CMP: begin
            alu_res   = rf_op_1 - rf_op_2;
            alu_carry = (rf_op_1 < rf_op_2);
         end
         OP_AND:  alu_res = rf_op_1 & rf_op_2;
         OP_OR:   alu_res = rf_op_1 | rf_op_2;
         OP_XOR:  alu_res = rf_op_1 ^ rf_op_2;
         OP_SLL:  alu_res = rf_op_1 << rf_op_2[4:0];
         OP_SRL:  alu_res = rf_op_1 >> rf_op_2[4:0];
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      rd_d      = rd_q;
      res_d     = res_q;
      zero_d    = zero_q;
      carry_d   = carry_q;
      cmd_ready = 1'b0;
      rf_rd     = 1'b0;
      rf_wr     = 1'b0;
      res_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               op_d    = cmd_op;
               rs1_d   = cmd_rs1;
               rs2_d   = cmd_rs2;
               rd_d    = cmd_rd;
               state_d = S_RD;
            end
         end
         S_RD: begin
            rf_rd   = 1'b1;
            state_d = S_EX;
         end
         S_EX: begin
            res_d   = alu_res;
            zero_d  = (alu_res == '0);
            carry_d = alu_carry;
            state_d = S_WB;
         end
         S_WB: begin
            res_valid = 1'b1;
            rf_wr     = (op_q != OP_CMP);
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Strobes are forced low while reset is held, even before the reset edge lands.
      if (!rst_n) begin
         cmd_ready = 1'b0;
         rf_rd     = 1'b0;
         rf_wr     = 1'b0;
         res_valid = 1'b0;
      end
   end

   // NOTE: state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
      end
   end

   assign rf_en     = rst_n;
   assign rf_sel_o1 = rs1_q;
   assign rf_sel_o2 = rs2_q;
   assign rf_sel_i1 = rd_q;
   assign rf_wdata  = res_q;
   assign res_data  = res_q;
   assign res_zero  = zero_q;
   assign res_carry = carry_q;

endmodule
